// File: rtl/mem_port.sv
// mem_port: single-transaction bridge between a processor data register and a
// synchronous RAM with a fixed read latency. One read or one write is in flight
// at a time; requests arriving while busy are dropped, not queued.
//
// Parameters
//   ADDR_W    address width in bits
//   READ_LAT  cycles from RAM request to valid ram_rdata (1..4)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   rd_req     in   read request, sampled only while idle
//   wr_req     in   write request, sampled only while idle (wins over rd_req)
//   addr       in   processor address, captured at the start edge
//   dr_data    in   write data, captured at the start edge
//   mem_bus    out  last completed read value (registered)
//   busy       out  transaction in progress
//   done       out  one-cycle completion pulse
//   req_err    out  one-cycle pulse when rd_req and wr_req collide
//   ram_en     out  RAM enable
//   ram_we     out  RAM write enable
//   ram_addr   out  RAM address
//   ram_wdata  out  RAM write data
//   ram_rdata  in   RAM read data
module mem_port #(
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        dr_data,
    output logic [7:0]        mem_bus,
    output logic              busy,
    output logic              done,
    output logic              req_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        memBus_q, memBus_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              reqErr_q, reqErr_d;
    logic              ramEn_q, ramEn_d;
    logic              ramWe_q, ramWe_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [7:0]        ramWdata_q, ramWdata_d;

    // Next-state and output logic. Every output is produced here as a register
    // input, so the pins never carry combinational paths from the inputs.
    // The wait counter is loaded with READ_LAT at the start edge and the read
    // completes on the edge where it still holds 1, giving exactly READ_LAT
    // edges between the request edge and the mem_bus update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memBus_d   = memBus_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        reqErr_d   = 1'b0;
        ramEn_d    = ramEn_q;
        ramWe_d    = ramWe_q;
        ramAddr_d  = ramAddr_q;
        ramWdata_d = ramWdata_q;

        case (state_q)
            IDLE: begin
                // A write wins a collision; the read is dropped and flagged.
                if (wr_req) begin
                    ramAddr_d  = addr;
                    ramWdata_d = dr_data;
                    ramEn_d    = 1'b1;
                    ramWe_d    = 1'b1;
                    busy_d     = 1'b1;
                    reqErr_d   = rd_req;
                    state_d    = WR;
                end else if (rd_req) begin
                    ramAddr_d  = addr;
                    ramEn_d    = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = 3'(READ_LAT);
                    state_d    = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (cnt_q == 3'd1) begin
                    memBus_d = ram_rdata;
                    busy_d   = 1'b0;
                    ramEn_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            WR: begin
                ramEn_d = 1'b0;
                ramWe_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                ramEn_d = 1'b0;
                ramWe_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight
    // without a done pulse and drops ram_we at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            memBus_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            reqErr_q   <= 1'b0;
            ramEn_q    <= 1'b0;
            ramWe_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramWdata_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memBus_q   <= memBus_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            reqErr_q   <= reqErr_d;
            ramEn_q    <= ramEn_d;
            ramWe_q    <= ramWe_d;
            ramAddr_q  <= ramAddr_d;
            ramWdata_q <= ramWdata_d;
        end
    end

    assign mem_bus   = memBus_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_err   = reqErr_q;
    assign ram_en    = ramEn_q;
    assign ram_we    = ramWe_q;
    assign ram_addr  = ramAddr_q;
    assign ram_wdata = ramWdata_q;

endmodule
